// File: rtl/tv80_regbank.sv
// TV80-style register bank: two 8-entry halves (H/L) with an alternate bank
// for shadowed registers (EXX) and DE/HL renaming per bank (EXDEHL).
module tv80_regbank #(
  parameter int                DW          = 8,
  parameter int                AW          = 3,
  parameter logic [2**AW-1:0]  SHADOW_MASK = 8'b0000_0111,
  parameter int                DE_ADDR     = 1,
  parameter int                HL_ADDR     = 2,
  parameter int                BYPASS      = 0,
  parameter logic [DW-1:0]     RST_VAL     = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CEN,
  input  logic [AW-1:0] AddrA,
  input  logic [AW-1:0] AddrB,
  input  logic [AW-1:0] AddrC,
  input  logic [DW-1:0] DIH,
  input  logic [DW-1:0] DIL,
  input  logic          WEH,
  input  logic          WEL,
  input  logic          EXX,
  input  logic          EXDEHL,
  output logic [DW-1:0] DOAH,
  output logic [DW-1:0] DOAL,
  output logic [DW-1:0] DOBH,
  output logic [DW-1:0] DOBL,
  output logic [DW-1:0] DOCH,
  output logic [DW-1:0] DOCL,
  output logic          bank_o,
  output logic [1:0]    dehl_o
);

  localparam int            NREG  = 2**AW;
  localparam int            NPHYS = 2*NREG;
  localparam logic [AW-1:0] DE_A  = AW'(DE_ADDR);
  localparam logic [AW-1:0] HL_A  = AW'(HL_ADDR);
  localparam logic          BYP   = (BYPASS != 0);

  logic [DW-1:0] regH_q [NPHYS];
  logic [DW-1:0] regL_q [NPHYS];
  logic          bank_q, bank_d;
  logic [1:0]    dehl_q, dehl_d;
  logic [AW:0]   physA, physB, physC;
  logic          wrH, wrL;

  // Shadow selection uses the logical address; DE/HL renaming only alters the low index bits.
  function automatic logic [AW:0] physIdx(input logic [AW-1:0] a,
                                          input logic          bank,
                                          input logic [1:0]    dehl);
    logic [AW-1:0] ren;
    ren = a;
    if (dehl[bank]) begin
      if (a == DE_A)      ren = HL_A;
      else if (a == HL_A) ren = DE_A;
    end
    return {SHADOW_MASK[a] & bank, ren};
  endfunction

  assign physA = physIdx(AddrA, bank_q, dehl_q);
  assign physB = physIdx(AddrB, bank_q, dehl_q);
  assign physC = physIdx(AddrC, bank_q, dehl_q);

  assign wrH = CEN & WEH;
  assign wrL = CEN & WEL;

  // Port A always addresses the write target, so its bypass needs no index compare.
  assign DOAH = (BYP && wrH) ? DIH : regH_q[physA];
  assign DOAL = (BYP && wrL) ? DIL : regL_q[physA];
  assign DOBH = (BYP && wrH && physB == physA) ? DIH : regH_q[physB];
  assign DOBL = (BYP && wrL && physB == physA) ? DIL : regL_q[physB];
  assign DOCH = (BYP && wrH && physC == physA) ? DIH : regH_q[physC];
  assign DOCL = (BYP && wrL && physC == physA) ? DIL : regL_q[physC];

  assign bank_o = bank_q;
  assign dehl_o = dehl_q;

  always_comb begin
    bank_d = bank_q;
    dehl_d = dehl_q;
    if (CEN && EXDEHL) dehl_d[bank_q] = ~dehl_q[bank_q];
    if (CEN && EXX)    bank_d = ~bank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= 1'b0;
      dehl_q <= 2'b00;
      for (int i = 0; i < NPHYS; i++) begin
        regH_q[i] <= RST_VAL;
        regL_q[i] <= RST_VAL;
      end
    end else begin
      bank_q <= bank_d;
      dehl_q <= dehl_d;
      if (wrH) regH_q[physA] <= DIH;
      if (wrL) regL_q[physA] <= DIL;
    end
  end

endmodule

// File: tb/tb_tv80_regbank.sv
// Self-checking bench for tv80_regbank: directed scenarios plus randomized traffic
// compared against a behavioural register-file model (BYPASS=0 and BYPASS=1 copies).
module tb_tv80_regbank;

  logic       clk = 1'b0;
  logic       reset, CEN, WEH, WEL, EXX, EXDEHL;
  logic [2:0] AddrA, AddrB, AddrC;
  logic [7:0] DIH, DIL;
  logic [7:0] DOAH, DOAL, DOBH, DOBL, DOCH, DOCL;
  logic [7:0] bDOAH, bDOAL, bDOBH, bDOBL, bDOCH, bDOCL;
  logic       bank_o, bBank;
  logic [1:0] dehl_o, bDehl;

  int nTests = 0;
  int nFail  = 0;

  // Model state: 16 physical entries per half, bank select and per-bank swap flags.
  logic [7:0] mH [16];
  logic [7:0] mL [16];
  int         mBank;
  logic [1:0] mDehl;
  localparam logic [7:0] SHADOW = 8'b0000_0111;

  tv80_regbank dut (
    .clk(clk), .reset(reset), .CEN(CEN), .AddrA(AddrA), .AddrB(AddrB), .AddrC(AddrC),
    .DIH(DIH), .DIL(DIL), .WEH(WEH), .WEL(WEL), .EXX(EXX), .EXDEHL(EXDEHL),
    .DOAH(DOAH), .DOAL(DOAL), .DOBH(DOBH), .DOBL(DOBL), .DOCH(DOCH), .DOCL(DOCL),
    .bank_o(bank_o), .dehl_o(dehl_o)
  );

  tv80_regbank #(.BYPASS(1)) dutB (
    .clk(clk), .reset(reset), .CEN(CEN), .AddrA(AddrA), .AddrB(AddrB), .AddrC(AddrC),
    .DIH(DIH), .DIL(DIL), .WEH(WEH), .WEL(WEL), .EXX(EXX), .EXDEHL(EXDEHL),
    .DOAH(bDOAH), .DOAL(bDOAL), .DOBH(bDOBH), .DOBL(bDOBL), .DOCH(bDOCH), .DOCL(bDOCL),
    .bank_o(bBank), .dehl_o(bDehl)
  );

  always #5 clk = ~clk;

  function automatic int mPhys(input logic [2:0] a);
    int r;
    r = a;
    if (mDehl[mBank] && a == 3'd1) r = 2;
    else if (mDehl[mBank] && a == 3'd2) r = 1;
    if (SHADOW[a]) r = r + 8 * mBank;
    return r;
  endfunction

  function automatic logic [7:0] mRead(input logic [2:0] a, input bit hi, input bit byp);
    int idx;
    idx = mPhys(a);
    if (byp && CEN && (hi ? WEH : WEL) && idx == mPhys(AddrA)) return hi ? DIH : DIL;
    return hi ? mH[idx] : mL[idx];
  endfunction

  function automatic logic [47:0] mAll(input bit byp);
    return {mRead(AddrA, 1, byp), mRead(AddrA, 0, byp), mRead(AddrB, 1, byp),
            mRead(AddrB, 0, byp), mRead(AddrC, 1, byp), mRead(AddrC, 0, byp)};
  endfunction

  task automatic modelStep();
    int w;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mH[i] = 8'h00;
        mL[i] = 8'h00;
      end
      mBank = 0;
      mDehl = 2'b00;
    end else if (CEN) begin
      w = mPhys(AddrA);
      if (WEH) mH[w] = DIH;
      if (WEL) mL[w] = DIL;
      if (EXDEHL) mDehl[mBank] = ~mDehl[mBank];
      if (EXX) mBank = 1 - mBank;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setIdle();
    reset = 0; CEN = 1; WEH = 0; WEL = 0; EXX = 0; EXDEHL = 0;
    DIH = 8'h00; DIL = 8'h00;
  endtask

  task automatic doReset();
    setIdle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic doWrite(input logic [2:0] a, input logic [7:0] h, input logic [7:0] l);
    AddrA = a; DIH = h; DIL = l; WEH = 1; WEL = 1;
    tick();
    setIdle();
  endtask

  task automatic test_reset();
    setIdle();
    AddrA = 0; AddrB = 0; AddrC = 0;
    reset = 1; WEH = 1; WEL = 1; DIH = 8'hFF; DIL = 8'hFF; EXX = 1; EXDEHL = 1;
    tick();
    setIdle();
    nTests++;
    if ({bank_o, dehl_o} !== 3'b000) begin
      nFail++;
      $display("[TB] FAIL reset_state: got bank/dehl %b, expected 000", {bank_o, dehl_o});
    end
    for (int a = 0; a < 8; a++) begin
      AddrA = 3'(a); AddrB = 3'(a); AddrC = 3'(a);
      #1;
      nTests++;
      if ({DOAH, DOAL, DOBH, DOBL, DOCH, DOCL} !== 48'h0) begin
        nFail++;
        $display("[TB] FAIL reset_regs a=%0d: got %h, expected 0", a,
                 {DOAH, DOAL, DOBH, DOBL, DOCH, DOCL});
      end
    end
  endtask

  task automatic test_exx();
    doReset();
    doWrite(0, 8'h12, 8'h34);
    EXX = 1; tick(); setIdle();
    doWrite(0, 8'h56, 8'h78);
    EXX = 1; tick(); setIdle();
    AddrA = 0; #1;
    nTests++;
    if ({DOAH, DOAL} !== 16'h1234) begin
      nFail++;
      $display("[TB] FAIL exx_bank0: got %h, expected 1234", {DOAH, DOAL});
    end
    EXX = 1; tick(); setIdle();
    AddrA = 0; #1;
    nTests++;
    if ({DOAH, DOAL} !== 16'h5678) begin
      nFail++;
      $display("[TB] FAIL exx_bank1: got %h, expected 5678", {DOAH, DOAL});
    end
  endtask

  task automatic test_exdehl();
    doReset();
    doWrite(1, 8'h11, 8'h11);
    doWrite(2, 8'h22, 8'h22);
    EXDEHL = 1; tick(); setIdle();
    AddrB = 1; AddrC = 2; #1;
    nTests++;
    if ({DOBH, DOBL, DOCH, DOCL, dehl_o} !== {32'h2222_1111, 2'b01}) begin
      nFail++;
      $display("[TB] FAIL exdehl_swap: got %h dehl %b, expected 22221111 dehl 01",
               {DOBH, DOBL, DOCH, DOCL}, dehl_o);
    end
    EXX = 1; tick(); setIdle();
    AddrB = 1; AddrC = 2; #1;
    nTests++;
    if ({bank_o, dehl_o, DOBH, DOBL, DOCH, DOCL} !== {1'b1, 2'b01, 32'h0}) begin
      nFail++;
      $display("[TB] FAIL exdehl_bank1: got bank %b dehl %b data %h, expected 1 01 0",
               bank_o, dehl_o, {DOBH, DOBL, DOCH, DOCL});
    end
  endtask

  task automatic test_nonshadow();
    doReset();
    doWrite(3, 8'hAB, 8'hCD);
    EXX = 1; tick(); setIdle();
    AddrA = 3; #1;
    nTests++;
    if ({DOAH, DOAL} !== 16'hABCD) begin
      nFail++;
      $display("[TB] FAIL ix_exx: got %h, expected abcd", {DOAH, DOAL});
    end
    AddrA = 3; DIH = 8'h99; DIL = 8'hEF; WEL = 1; tick(); setIdle();
    AddrA = 3; #1;
    nTests++;
    if ({DOAH, DOAL} !== 16'hABEF) begin
      nFail++;
      $display("[TB] FAIL ix_wel: got %h, expected abef", {DOAH, DOAL});
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    AddrA = 2; DIH = 8'h77; DIL = 8'h88; WEH = 1; WEL = 1; EXX = 1; EXDEHL = 1;
    tick(); setIdle();
    nTests++;
    if ({bank_o, dehl_o} !== 3'b101) begin
      nFail++;
      $display("[TB] FAIL combo_flags: got %b, expected 101", {bank_o, dehl_o});
    end
    // Back in bank 0 with DE/HL swapped, logical DE lands on physical HL.
    EXX = 1; tick(); setIdle();
    AddrB = 1; AddrC = 2; #1;
    nTests++;
    if ({DOBH, DOBL, DOCH, DOCL} !== 32'h7788_0000) begin
      nFail++;
      $display("[TB] FAIL combo_data: got %h, expected 77880000", {DOBH, DOBL, DOCH, DOCL});
    end
  endtask

  task automatic test_bypass();
    doReset();
    doWrite(5, 8'h11, 8'h22);
    AddrA = 5; AddrB = 5; DIH = 8'h5A; DIL = 8'h5A; WEH = 1; WEL = 1; #1;
    nTests++;
    if ({bDOBH, bDOBL} !== 16'h5A5A) begin
      nFail++;
      $display("[TB] FAIL bypass_on: got %h, expected 5a5a", {bDOBH, bDOBL});
    end
    nTests++;
    if ({DOBH, DOBL} !== 16'h1122) begin
      nFail++;
      $display("[TB] FAIL bypass_off: got %h, expected 1122", {DOBH, DOBL});
    end
    tick(); setIdle();
    AddrB = 5; #1;
    nTests++;
    if ({DOBH, DOBL} !== 16'h5A5A) begin
      nFail++;
      $display("[TB] FAIL bypass_commit: got %h, expected 5a5a", {DOBH, DOBL});
    end
  endtask

  task automatic test_cen();
    doReset();
    doWrite(0, 8'hC3, 8'h3C);
    CEN = 0; AddrA = 0; DIH = 8'hFF; DIL = 8'hFF; WEH = 1; WEL = 1; EXX = 1; EXDEHL = 1;
    tick();
    AddrB = 0; #1;
    nTests++;
    if ({bank_o, dehl_o, DOBH, DOBL} !== {3'b000, 16'hC33C}) begin
      nFail++;
      $display("[TB] FAIL cen_hold: got %h, expected 0c33c", {bank_o, dehl_o, DOBH, DOBL});
    end
    setIdle();
    EXX = 1; tick(); setIdle();
    CEN = 0; reset = 1; tick(); setIdle();
    AddrA = 0; AddrB = 0; #1;
    nTests++;
    if ({bank_o, DOAH, DOAL} !== 17'h0) begin
      nFail++;
      $display("[TB] FAIL cen_reset: got %h, expected 0", {bank_o, DOAH, DOAL});
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 40) == 0);
      CEN    = ($urandom_range(0, 3) != 0);
      WEH    = $urandom_range(0, 1) == 1;
      WEL    = $urandom_range(0, 1) == 1;
      EXX    = ($urandom_range(0, 5) == 0);
      EXDEHL = ($urandom_range(0, 5) == 0);
      AddrA  = 3'($urandom_range(0, 7));
      AddrB  = 3'($urandom_range(0, 7));
      AddrC  = 3'($urandom_range(0, 7));
      DIH    = 8'($urandom);
      DIL    = 8'($urandom);
      #1;
      nTests++;
      if ({DOAH, DOAL, DOBH, DOBL, DOCH, DOCL} !== mAll(0) ||
          {bank_o, dehl_o} !== {mBank[0], mDehl}) begin
        nFail++;
        $display("[TB] FAIL rand_nobyp i=%0d: got %h/%b%b, expected %h/%0d%b", i,
                 {DOAH, DOAL, DOBH, DOBL, DOCH, DOCL}, bank_o, dehl_o, mAll(0), mBank, mDehl);
      end
      nTests++;
      if ({bDOAH, bDOAL, bDOBH, bDOBL, bDOCH, bDOCL} !== mAll(1)) begin
        nFail++;
        $display("[TB] FAIL rand_byp i=%0d: got %h, expected %h", i,
                 {bDOAH, bDOAL, bDOBH, bDOBL, bDOCH, bDOCL}, mAll(1));
      end
      tick();
    end
    setIdle();
  endtask

  initial begin
    setIdle();
    AddrA = 0; AddrB = 0; AddrC = 0;
    mBank = 0;
    mDehl = 2'b00;
    test_reset();
    test_exx();
    test_exdehl();
    test_nonshadow();
    test_back_to_back();
    test_bypass();
    test_cen();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
